// File: rtl/arf_pkg.sv
// Shared encodings for the address register file: FunSel operation codes
// and the burst engine state type.
package arf_pkg;

   localparam logic [1:0] FS_DEC  = 2'b00;
   localparam logic [1:0] FS_INC  = 2'b01;
   localparam logic [1:0] FS_LOAD = 2'b10;
   localparam logic [1:0] FS_CLR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } burst_state_e;

endpackage : arf_pkg

// File: rtl/arf_reg.sv
// One address register: decrement, increment, load or clear when enabled,
// otherwise hold. Reset value is set per instance.
module arf_reg
   import arf_pkg::*;
#(
   parameter int               WIDTH   = 16,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [1:0]       fun_sel_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      // NOTE: assigning the hold value first keeps every path covered, so no latch is inferred.
      q_d = q_q;
      if (en_i) begin
         case (fun_sel_i)
            FS_DEC:  q_d = q_q - WIDTH'(1);
            FS_INC:  q_d = q_q + WIDTH'(1);
            FS_LOAD: q_d = data_i;
            FS_CLR:  q_d = '0;
            default: q_d = q_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule : arf_reg

// File: rtl/addr_reg_file_burst.sv
// Address register file (PC/SP/AR by default) with two combinational read
// ports, sticky SP bound flags and an AR auto-increment burst engine.
module addr_reg_file_burst
   import arf_pkg::*;
#(
   parameter int               WIDTH    = 16,
   parameter int               NUM_REGS = 3,
   parameter int               PC_IDX   = 0,
   parameter int               SP_IDX   = 1,
   parameter int               AR_IDX   = 2,
   parameter logic [WIDTH-1:0] PC_RST   = '0,
   parameter logic [WIDTH-1:0] SP_LO    = 16'h0100,
   parameter logic [WIDTH-1:0] SP_HI    = 16'hFFFF,
   parameter int               LEN_W    = 8,
   localparam int              SEL_W    = $clog2(NUM_REGS)
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [WIDTH-1:0]    I,
   input  logic [NUM_REGS-1:0] RegSel,
   input  logic [1:0]          FunSel,
   input  logic [SEL_W-1:0]    OutCSel,
   input  logic [SEL_W-1:0]    OutDSel,
   output logic [WIDTH-1:0]    OutC,
   output logic [WIDTH-1:0]    OutD,
   input  logic                BurstStart,
   input  logic [LEN_W-1:0]    BurstLen,
   output logic                BurstBusy,
   output logic                BurstDone,
   input  logic                FlagClr,
   output logic                SpOvf,
   output logic                SpUnf
);

   logic [WIDTH-1:0]    reg_q  [NUM_REGS];
   logic [NUM_REGS-1:0] reg_en;
   logic [1:0]          reg_fs [NUM_REGS];

   burst_state_e        state_q, state_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;

   logic                sp_dec_at_lo;
   logic                sp_inc_at_hi;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;

   // SP bound violations: the write is suppressed and the matching flag raised.
   assign sp_dec_at_lo = RegSel[SP_IDX] && (FunSel == FS_DEC) && (reg_q[SP_IDX] == SP_LO);
   assign sp_inc_at_hi = RegSel[SP_IDX] && (FunSel == FS_INC) && (reg_q[SP_IDX] == SP_HI);

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_en[i] = RegSel[i];
         reg_fs[i] = FunSel;
      end
      reg_en[SP_IDX] = RegSel[SP_IDX] && !sp_dec_at_lo && !sp_inc_at_hi;
      // The burst owns AR from start until it returns to idle.
      if (state_q != ST_IDLE) begin
         reg_en[AR_IDX] = 1'b0;
      end
      if (state_q == ST_RUN) begin
         reg_en[AR_IDX] = 1'b1;
         reg_fs[AR_IDX] = FS_INC;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      localparam logic [WIDTH-1:0] RST_VAL = (g == PC_IDX) ? PC_RST :
                                             (g == SP_IDX) ? SP_HI  : '0;
      arf_reg #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_reg (
         .clk_i     (Clock),
         .rst_ni    (Reset),
         .en_i      (reg_en[g]),
         .fun_sel_i (reg_fs[g]),
         .data_i    (I),
         .q_o       (reg_q[g])
      );
   end

   // A same-cycle set wins over FlagClr.
   assign ovf_d = sp_dec_at_lo || (ovf_q && !FlagClr);
   assign unf_d = sp_inc_at_hi || (unf_q && !FlagClr);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign SpOvf = ovf_q;
   assign SpUnf = unf_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      BurstBusy = 1'b0;
      BurstDone = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (BurstStart) begin
               if (BurstLen != '0) begin
                  cnt_d   = BurstLen;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            BurstBusy = 1'b1;
            cnt_d     = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            BurstDone = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Out-of-range selects fall back to the last register.
   always_comb begin
      OutC = reg_q[NUM_REGS-1];
      OutD = reg_q[NUM_REGS-1];
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(OutCSel) == i) OutC = reg_q[i];
         if (int'(OutDSel) == i) OutD = reg_q[i];
      end
   end

endmodule : addr_reg_file_burst

// File: tb/tb_addr_reg_file_burst.sv
// Scoreboard bench for addr_reg_file_burst: register ops, SP bounds,
// read fallback, bursts and asynchronous reset.
module tb_addr_reg_file_burst;
   import arf_pkg::*;

   logic        Clock;
   logic        Reset;
   logic [15:0] I;
   logic [2:0]  RegSel;
   logic [1:0]  FunSel;
   logic [1:0]  OutCSel;
   logic [1:0]  OutDSel;
   logic [15:0] OutC;
   logic [15:0] OutD;
   logic        BurstStart;
   logic [7:0]  BurstLen;
   logic        BurstBusy;
   logic        BurstDone;
   logic        FlagClr;
   logic        SpOvf;
   logic        SpUnf;

   addr_reg_file_burst dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .I          (I),
      .RegSel     (RegSel),
      .FunSel     (FunSel),
      .OutCSel    (OutCSel),
      .OutDSel    (OutDSel),
      .OutC       (OutC),
      .OutD       (OutD),
      .BurstStart (BurstStart),
      .BurstLen   (BurstLen),
      .BurstBusy  (BurstBusy),
      .BurstDone  (BurstDone),
      .FlagClr    (FlagClr),
      .SpOvf      (SpOvf),
      .SpUnf      (SpUnf)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] sp;
      logic [15:0] ar;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t        m;
   exp_t        exp_q[$];
   logic [15:0] ar_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] apply(input logic [15:0] v, input logic [1:0] fs,
                                         input logic [15:0] d);
      case (fs)
         2'b00:   return v - 16'd1;
         2'b01:   return v + 16'd1;
         2'b10:   return d;
         default: return 16'd0;
      endcase
   endfunction

   task automatic rd(input int idx, output logic [15:0] v);
      OutCSel = 2'(idx);
      #1;
      v = OutC;
   endtask

   task automatic compare(input string tag);
      exp_t        e;
      logic [15:0] pc, sp, ar;
      check({tag, "_sb_avail"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         rd(0, pc);
         rd(1, sp);
         rd(2, ar);
         check({tag, "_pc"}, 32'(pc), 32'(e.pc));
         check({tag, "_sp"}, 32'(sp), 32'(e.sp));
         check({tag, "_ar"}, 32'(ar), 32'(e.ar));
         check({tag, "_ovf"}, 32'(SpOvf), 32'(e.ovf));
         check({tag, "_unf"}, 32'(SpUnf), 32'(e.unf));
      end
   endtask

   // Drive one register op with the burst idle; the expected state comes from the model.
   task automatic op(input logic [2:0] sel, input logic [1:0] fs, input logic [15:0] d,
                     input logic fclr, input string tag);
      exp_t nx;
      logic o, u;
      RegSel = sel; FunSel = fs; I = d; FlagClr = fclr;
      nx = m; o = 1'b0; u = 1'b0;
      if (sel[0]) nx.pc = apply(m.pc, fs, d);
      if (sel[1]) begin
         if (fs == 2'b00 && m.sp == 16'h0100)      o = 1'b1;
         else if (fs == 2'b01 && m.sp == 16'hFFFF) u = 1'b1;
         else                                      nx.sp = apply(m.sp, fs, d);
      end
      if (sel[2]) nx.ar = apply(m.ar, fs, d);
      nx.ovf = o | (m.ovf & ~fclr);
      nx.unf = u | (m.unf & ~fclr);
      m = nx;
      exp_q.push_back(m);
      @(posedge Clock);
      #1;
      RegSel = 3'b000; FlagClr = 1'b0;
      compare(tag);
   endtask

   task automatic check_reset_state(input string tag);
      logic [15:0] v;
      rd(0, v); check({tag, "_pc"}, 32'(v), 32'h0000);
      rd(1, v); check({tag, "_sp"}, 32'(v), 32'hFFFF);
      rd(2, v); check({tag, "_ar"}, 32'(v), 32'h0000);
      check({tag, "_ovf"},  32'(SpOvf), 32'd0);
      check({tag, "_unf"},  32'(SpUnf), 32'd0);
      check({tag, "_busy"}, 32'(BurstBusy), 32'd0);
      check({tag, "_done"}, 32'(BurstDone), 32'd0);
   endtask

   initial begin
      logic [15:0] v;
      int          busy_n, done_n, done_at;

      Reset = 1'b0; I = '0; RegSel = '0; FunSel = '0; OutCSel = '0; OutDSel = '0;
      BurstStart = 1'b0; BurstLen = '0; FlagClr = 1'b0;
      m = '{pc: 16'h0000, sp: 16'hFFFF, ar: 16'h0000, ovf: 1'b0, unf: 1'b0};

      #12;
      check_reset_state("rst0");
      Reset = 1'b1;
      @(posedge Clock);
      #1;

      // Load all three in one cycle, then read SP and the out-of-range fallback.
      op(3'b111, FS_LOAD, 16'h1234, 1'b0, "ld_all");
      OutCSel = 2'd1; OutDSel = 2'd3;
      #1;
      check("rd_c_sp", 32'(OutC), 32'h1234);
      check("rd_d_fallback", 32'(OutD), 32'h1234);
      op(3'b100, FS_LOAD, 16'h5A5A, 1'b0, "ld_ar");
      OutDSel = 2'd3;
      #1;
      check("rd_d_fallback_ar", 32'(OutD), 32'h5A5A);
      OutDSel = 2'd0;
      #1;
      check("rd_d_pc", 32'(OutD), 32'h1234);

      // PC wraps both ways; RegSel=0 holds.
      op(3'b001, FS_LOAD, 16'hFFFF, 1'b0, "pc_ld");
      op(3'b001, FS_INC,  16'h0000, 1'b0, "pc_wrap_up");
      op(3'b001, FS_DEC,  16'h0000, 1'b0, "pc_wrap_dn");
      op(3'b001, FS_CLR,  16'h0000, 1'b0, "pc_clr");
      op(3'b000, FS_INC,  16'h0000, 1'b0, "hold");

      // SP lower bound, flag priority over clear, then clear.
      op(3'b010, FS_LOAD, 16'h0101, 1'b0, "sp_ld");
      op(3'b010, FS_DEC,  16'h0000, 1'b0, "sp_dec_ok");
      op(3'b010, FS_DEC,  16'h0000, 1'b0, "sp_ovf");
      op(3'b010, FS_DEC,  16'h0000, 1'b1, "sp_ovf_setclr");
      op(3'b000, FS_DEC,  16'h0000, 1'b1, "sp_ovf_clr");
      // SP upper bound.
      op(3'b010, FS_LOAD, 16'hFFFF, 1'b0, "sp_ld_hi");
      op(3'b010, FS_INC,  16'h0000, 1'b0, "sp_unf");
      op(3'b000, FS_INC,  16'h0000, 1'b1, "sp_unf_clr");

      // Burst of 3 across the AR wrap, with an AR load (ignored) and a PC load (honoured).
      op(3'b100, FS_LOAD, 16'hFFFE, 1'b0, "burst_ar_ld");
      BurstStart = 1'b1; BurstLen = 8'd3;
      ar_q.push_back(16'hFFFE);
      ar_q.push_back(16'hFFFF);
      ar_q.push_back(16'h0000);
      for (int k = 3; k < 8; k++) ar_q.push_back(16'h0001);
      @(posedge Clock);
      #1;
      BurstStart = 1'b0;
      busy_n = 0; done_n = 0; done_at = -1;
      for (int k = 0; k < 8; k++) begin
         if (BurstBusy) busy_n++;
         if (BurstDone) begin
            done_n++;
            if (done_at < 0) done_at = k;
         end
         rd(2, v);
         check("burst_sb_avail", 32'(ar_q.size() != 0), 32'd1);
         if (ar_q.size() != 0) check($sformatf("burst_ar_%0d", k), 32'(v), 32'(ar_q.pop_front()));
         if (k < 4) begin
            RegSel = 3'b101; FunSel = FS_LOAD; I = 16'hAAAA;
         end else begin
            RegSel = 3'b000;
         end
         @(posedge Clock);
         #1;
      end
      RegSel = 3'b000;
      check("burst_busy_cycles", 32'(busy_n), 32'd3);
      check("burst_done_count", 32'(done_n), 32'd1);
      check("burst_done_cycle", 32'(done_at), 32'd3);
      rd(0, v);
      check("burst_pc_normal", 32'(v), 32'hAAAA);
      m.pc = 16'hAAAA; m.ar = 16'h0001;

      // Zero-length burst: no increment, immediate done, never busy.
      BurstStart = 1'b1; BurstLen = 8'd0;
      @(posedge Clock);
      #1;
      BurstStart = 1'b0;
      busy_n = 0; done_n = 0; done_at = -1;
      for (int k = 0; k < 4; k++) begin
         if (BurstBusy) busy_n++;
         if (BurstDone) begin
            done_n++;
            if (done_at < 0) done_at = k;
         end
         rd(2, v);
         check($sformatf("len0_ar_%0d", k), 32'(v), 32'h0001);
         @(posedge Clock);
         #1;
      end
      check("len0_busy", 32'(busy_n), 32'd0);
      check("len0_done_count", 32'(done_n), 32'd1);
      check("len0_done_cycle", 32'(done_at), 32'd0);

      // Reset during RUN after two increments, with a flag set.
      op(3'b010, FS_INC,  16'h0000, 1'b0, "pre_rst_unf");
      op(3'b100, FS_LOAD, 16'h0010, 1'b0, "pre_rst_ar");
      BurstStart = 1'b1; BurstLen = 8'd5;
      @(posedge Clock);
      #1;
      BurstStart = 1'b0;
      @(posedge Clock);
      @(posedge Clock);
      #1;
      rd(2, v);
      check("run_ar_2inc", 32'(v), 32'h0012);
      check("run_busy", 32'(BurstBusy), 32'd1);
      #1;
      Reset = 1'b0;
      #1;
      check_reset_state("rst_run");
      Reset = 1'b1;
      busy_n = 0; done_n = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge Clock);
         #1;
         if (BurstBusy) busy_n++;
         if (BurstDone) done_n++;
      end
      check("post_rst_busy", 32'(busy_n), 32'd0);
      check("post_rst_done", 32'(done_n), 32'd0);
      rd(2, v);
      check("post_rst_ar", 32'(v), 32'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_addr_reg_file_burst
